// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak padding types, domain-separator bytes and mode decode
package keccak_pkg;

  localparam int w = 64;

  typedef enum logic [1:0] {
    MODE_KECCAK    = 2'd0,
    MODE_SHA3      = 2'd1,
    MODE_SHAKE     = 2'd2,
    MODE_SHAKE_ALT = 2'd3
  } pad_mode_t;

  localparam logic [7:0] DS_KECCAK           = 8'h01;
  localparam logic [7:0] DS_SHA3             = 8'h06;
  localparam logic [7:0] DS_SHAKE            = 8'h1F;
  localparam logic [7:0] PAD_TERMINATOR_BYTE = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    PAD    = 2'd2,
    DONE   = 2'd3
  } padder_state_t;

  // The spare encoding 2'b11 decodes as SHAKE.
  function automatic logic [7:0] ds_for_mode(input pad_mode_t mode);
    case (mode)
      MODE_KECCAK: return DS_KECCAK;
      MODE_SHA3:   return DS_SHA3;
      default:     return DS_SHAKE;
    endcase
  endfunction

endpackage

// File: rtl/keccak_pad_word_builder.sv
// rtl/keccak_pad_word_builder.sv - combinational pad10*1 word former (keep k bytes, insert ds, OR terminator)
module keccak_pad_word_builder
  import keccak_pkg::*;
#(
  parameter int W  = 64,
  parameter int KW = $clog2(W/8) + 1
) (
  input  logic [W-1:0]  data,
  input  logic [KW-1:0] k,
  input  logic [7:0]    ds,
  input  logic          insert_ds,
  input  logic          block_end,
  output logic [W-1:0]  padded_word
);

  localparam int NB = W / 8;

  // Byte 0 is the most significant byte; the terminator lands in the last byte [7:0].
  always_comb begin
    padded_word = '0;
    for (int i = 0; i < NB; i++) begin
      if (KW'(i) < k) begin
        padded_word[W-1-8*i -: 8] = data[W-1-8*i -: 8];
      end else if ((KW'(i) == k) && insert_ds) begin
        padded_word[W-1-8*i -: 8] = ds;
      end
    end
    if (block_end) begin
      padded_word[7:0] = padded_word[7:0] | PAD_TERMINATOR_BYTE;
    end
  end

endmodule

// File: rtl/keccak_stream_padder.sv
// rtl/keccak_stream_padder.sv - streaming multi-mode pad10*1 padder in front of the Keccak absorb datapath
module keccak_stream_padder
  import keccak_pkg::*;
#(
  parameter int W              = 64,
  parameter int MAX_RATE_WORDS = 21,
  localparam int RW            = $clog2(MAX_RATE_WORDS + 1),
  localparam int KW            = $clog2(W/8) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode_i,
  input  logic [RW-1:0] rate_words_i,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [KW-1:0] in_bytes,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_block_end,
  output logic          out_last
);

  localparam logic [KW-1:0] FULL_BYTES = KW'(W/8);
  localparam logic [RW-1:0] MAX_RATE   = RW'(MAX_RATE_WORDS);

  padder_state_t state_q, state_d;
  logic [RW-1:0] word_idx_q, word_idx_d;
  logic [RW-1:0] rate_q, rate_d;
  logic [7:0]    ds_q, ds_d;
  logic          ds_pending_q, ds_pending_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_block_end_q, out_block_end_d;
  logic          out_last_q, out_last_d;

  logic          load;
  logic          at_block_end;
  logic [RW-1:0] word_idx_next;
  logic [RW-1:0] rate_clamped;
  logic [KW-1:0] in_bytes_c;
  logic          last_partial;

  logic [W-1:0]  bld_data;
  logic [KW-1:0] bld_k;
  logic          bld_insert_ds;
  logic          bld_block_end;
  logic [W-1:0]  bld_word;

  assign load          = !out_valid_q || out_ready;
  assign at_block_end  = (word_idx_q == (rate_q - RW'(1)));
  assign word_idx_next = at_block_end ? '0 : (word_idx_q + RW'(1));
  assign rate_clamped  = ((rate_words_i == '0) || (rate_words_i > MAX_RATE)) ? MAX_RATE : rate_words_i;
  assign in_bytes_c    = (in_bytes > FULL_BYTES) ? FULL_BYTES : in_bytes;
  assign last_partial  = in_last && (in_bytes_c != FULL_BYTES);
  assign in_ready      = (state_q == ABSORB) && !start && load;

  // PAD feeds an all-zero word through the same builder; ABSORB only pads a short last word.
  always_comb begin
    bld_data      = in_data;
    bld_k         = FULL_BYTES;
    bld_insert_ds = 1'b0;
    bld_block_end = 1'b0;
    if (state_q == PAD) begin
      bld_data      = '0;
      bld_k         = '0;
      bld_insert_ds = ds_pending_q;
      bld_block_end = at_block_end;
    end else if (last_partial) begin
      bld_k         = in_bytes_c;
      bld_insert_ds = 1'b1;
      bld_block_end = at_block_end;
    end
  end

  keccak_pad_word_builder #(
    .W  (W),
    .KW (KW)
  ) u_builder (
    .data        (bld_data),
    .k           (bld_k),
    .ds          (ds_q),
    .insert_ds   (bld_insert_ds),
    .block_end   (bld_block_end),
    .padded_word (bld_word)
  );

  always_comb begin
    state_d         = state_q;
    word_idx_d      = word_idx_q;
    rate_d          = rate_q;
    ds_d            = ds_q;
    ds_pending_d    = ds_pending_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    out_block_end_d = out_block_end_q;
    out_last_d      = out_last_q;

    if (start) begin
      // Abandons whatever is in flight, including an un-acknowledged output word.
      state_d         = ABSORB;
      word_idx_d      = '0;
      ds_pending_d    = 1'b0;
      ds_d            = ds_for_mode(pad_mode_t'(mode_i));
      rate_d          = rate_clamped;
      out_valid_d     = 1'b0;
      out_block_end_d = 1'b0;
      out_last_d      = 1'b0;
    end else if (load) begin
      out_valid_d     = 1'b0;
      out_block_end_d = 1'b0;
      out_last_d      = 1'b0;
      case (state_q)
        ABSORB: begin
          if (in_valid) begin
            out_valid_d     = 1'b1;
            out_data_d      = bld_word;
            out_block_end_d = at_block_end;
            word_idx_d      = word_idx_next;
            if (in_last) begin
              if (last_partial) begin
                ds_pending_d = 1'b0;
                out_last_d   = at_block_end;
                state_d      = at_block_end ? DONE : PAD;
              end else begin
                // A full last word leaves no room: ds goes into the next generated word.
                ds_pending_d = 1'b1;
                state_d      = PAD;
              end
            end
          end
        end
        PAD: begin
          out_valid_d     = 1'b1;
          out_data_d      = bld_word;
          out_block_end_d = at_block_end;
          out_last_d      = at_block_end;
          ds_pending_d    = 1'b0;
          word_idx_d      = word_idx_next;
          if (at_block_end) begin
            state_d = DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      word_idx_q      <= '0;
      rate_q          <= '0;
      ds_q            <= '0;
      ds_pending_q    <= 1'b0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
      out_block_end_q <= 1'b0;
      out_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_idx_q      <= word_idx_d;
      rate_q          <= rate_d;
      ds_q            <= ds_d;
      ds_pending_q    <= ds_pending_d;
      out_data_q      <= out_data_d;
      out_valid_q     <= out_valid_d;
      out_block_end_q <= out_block_end_d;
      out_last_q      <= out_last_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_block_end = out_block_end_q;
  assign out_last      = out_last_q;

endmodule
